// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and RAM bus types for the scanout/draw arbiter.
package fb_pkg;
    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int FB_DEPTH = H_RES * V_RES;
    localparam int ADDR_W   = 19;
    localparam int PIX_W    = 4;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE
    } ram_op_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [PIX_W-1:0]  wdata;
    } ram_req_t;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
        return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    endfunction
endpackage

// File: rtl/fb_prefetch_fifo.sv
// Scanout prefetch FIFO: flush wins over push/pop, pop on empty is ignored.
module fb_prefetch_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 din,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [W-1:0]                 head
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [IW-1:0] rp, wp;
    logic          do_push, do_pop;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !flush && !rst;
    assign do_pop  = pop && (count != '0) && !flush;
    assign head    = (count != '0) ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wp <= inc(wp);
            if (do_pop)
                rp <= inc(rp);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fb_ram_arbiter.sv
// Single-port framebuffer RAM arbiter: scanout prefetch reads vs draw-side writes,
// reads take priority whenever the prefetch occupancy drops below LOW_WATER.
module fb_ram_arbiter
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LOW_WATER  = 4,
    parameter int SCAN_WORDS = FB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              underrun,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [9:0]        wr_x,
    input  logic [8:0]        wr_y,
    input  logic [PIX_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [PIX_W-1:0]  ram_wdata,
    input  logic [PIX_W-1:0]  ram_rdata
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;

    logic [CW-1:0]     fifo_count;
    logic [PIX_W-1:0]  fifo_head;
    // [0]: read address on the bus, [1]: its data on ram_rdata this cycle
    logic [1:0]        vld_pipe;
    logic [OW-1:0]     occ;
    logic              rd_pri, rd_grant, wr_grant, wr_in_range;
    logic [ADDR_W-1:0] scan_ptr, wr_addr;
    ram_op_e           op;
    ram_req_t          bus;

    assign occ         = OW'(fifo_count) + OW'(vld_pipe[0]) + OW'(vld_pipe[1]);
    assign rd_pri      = occ < OW'(LOW_WATER);
    assign wr_grant    = !rst && wr_valid && !rd_pri;
    // No read in the flush cycle: it would only be squashed, and the restart at 0 follows next cycle.
    assign rd_grant    = !rst && !frame_start && (rd_pri || (!wr_valid && occ < OW'(FIFO_DEPTH)));
    assign wr_in_range = (wr_x < 10'(H_RES)) && (wr_y < 9'(V_RES));
    assign wr_addr     = pix_addr(wr_x, wr_y);

    always_comb begin
        op = OP_IDLE;
        if (rd_grant)
            op = OP_READ;
        else if (wr_grant && wr_in_range)
            op = OP_WRITE;
    end

    assign wr_ready  = wr_grant;
    assign pix_valid = !rst && (fifo_count != '0);
    assign pix_data  = rst ? '0 : fifo_head;
    assign underrun  = !rst && pix_pop && (fifo_count == '0);

    assign ram_addr  = bus.addr;
    assign ram_we    = bus.we;
    assign ram_wdata = bus.wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus      <= '0;
            scan_ptr <= '0;
            vld_pipe <= '0;
        end else begin
            bus.we   <= 1'b0;
            vld_pipe <= frame_start ? 2'b00 : {vld_pipe[0], rd_grant};
            case (op)
                OP_READ:  bus.addr <= scan_ptr;
                OP_WRITE: begin
                    bus.addr  <= wr_addr;
                    bus.we    <= 1'b1;
                    bus.wdata <= wr_data;
                end
                default: ;
            endcase
            if (frame_start)
                scan_ptr <= '0;
            else if (rd_grant)
                scan_ptr <= (scan_ptr == ADDR_W'(SCAN_WORDS - 1)) ? '0 : scan_ptr + 1'b1;
        end
    end

    fb_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_pipe[1]),
        .pop   (pix_pop),
        .flush (frame_start),
        .din   (ram_rdata),
        .count (fifo_count),
        .head  (fifo_head)
    );
endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Directed + randomized bench for fb_ram_arbiter against a queue-based reference model.
module tb_fb_ram_arbiter;
    import fb_pkg::*;

    localparam int DEPTH = 8;
    localparam int LW    = 4;
    localparam int SCAN  = 100;

    logic        clk = 1'b0, rst = 1'b1, frame_start = 1'b0, pix_pop = 1'b0, wr_valid = 1'b0;
    logic [9:0]  wr_x = '0;
    logic [8:0]  wr_y = '0;
    logic [3:0]  wr_data = '0, ram_rdata = '0;
    logic [3:0]  pix_data, ram_wdata;
    logic        pix_valid, underrun, wr_ready, ram_we;
    logic [18:0] ram_addr;

    int errors = 0, checks = 0;

    // reference model state
    logic [3:0] q[$];
    int         infl_a[$], infl_r[$];
    int         ptr = 0, occ, e_addr = 0;
    logic       e_we = 1'b0, m_wr = 1'b0, m_rd = 1'b0;
    logic [3:0] e_wd = '0;
    int         prev_addr, wraps;

    fb_ram_arbiter #(.FIFO_DEPTH(DEPTH), .LOW_WATER(LW), .SCAN_WORDS(SCAN)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_pop(pix_pop),
        .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] hashf(input logic [31:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ 4'h5;
    endfunction

    // synchronous RAM: data for the address sampled at an edge is visible after that edge
    always @(posedge clk) ram_rdata <= hashf(32'(ram_addr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [31:0] ehead;
        @(negedge clk);
        occ  = q.size() + infl_a.size();
        m_wr = !rst && wr_valid && occ >= LW;
        m_rd = !rst && !frame_start && (occ < LW || (!wr_valid && occ < DEPTH));
        ehead = 0;
        if (!rst && q.size() != 0) ehead = 32'(q[0]);
        chk("wr_ready", 32'(wr_ready), 32'(m_wr));
        chk("pix_valid", 32'(pix_valid), 32'(!rst && q.size() != 0));
        chk("pix_data", 32'(pix_data), ehead);
        chk("underrun", 32'(underrun), 32'(!rst && pix_pop && q.size() == 0));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
        if (rst) begin
            q.delete(); infl_a.delete(); infl_r.delete();
            ptr = 0; e_we = 0; e_addr = 0; e_wd = 0;
        end else begin
            e_we = 0;
            if (m_wr && wr_x < 640 && wr_y < 480) begin
                e_we = 1; e_addr = int'(wr_y) * 640 + int'(wr_x); e_wd = wr_data;
            end
            if (frame_start) begin
                q.delete(); infl_a.delete(); infl_r.delete(); ptr = 0;
            end else begin
                if (pix_pop && q.size() > 0) void'(q.pop_front());
                foreach (infl_r[i]) infl_r[i]--;
                while (infl_r.size() > 0 && infl_r[0] == 0) begin
                    q.push_back(hashf(32'(infl_a[0])));
                    void'(infl_a.pop_front());
                    void'(infl_r.pop_front());
                end
            end
            if (m_rd) begin
                infl_a.push_back(ptr); infl_r.push_back(2);
                e_addr = ptr; ptr = (ptr + 1) % SCAN;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        cycle(); cycle();
        rst = 1'b0;

        // fill after reset: reads 0..7 back to back, then idle
        repeat (12) cycle();
        chk("fill_valid", 32'(pix_valid), 1);
        chk("fill_head", 32'(pix_data), 32'(hashf(0)));
        chk("fill_last_addr", 32'(ram_addr), 7);

        // write at full FIFO
        wr_valid = 1; wr_x = 5; wr_y = 2; wr_data = 4'hA;
        #1 chk("full_wr_ready", 32'(wr_ready), 1);
        cycle();
        wr_valid = 0;
        chk("wr_we", 32'(ram_we), 1);
        chk("wr_addr", 32'(ram_addr), 1285);
        chk("wr_wdata", 32'(ram_wdata), 32'hA);

        // off-screen write is accepted but dropped
        wr_valid = 1; wr_x = 640; wr_y = 0; wr_data = 4'h3;
        #1 chk("oob_ready", 32'(wr_ready), 1);
        cycle();
        wr_valid = 0;
        chk("oob_we", 32'(ram_we), 0);

        // continuous pop with a pending write stream
        wr_valid = 1; wr_x = 1; wr_y = 1; wr_data = 4'h6; pix_pop = 1;
        repeat (30) begin
            cycle();
            chk("sustain_underrun", 32'(underrun), 0);
        end

        // frame_start with two reads in flight
        wr_valid = 0; frame_start = 1;
        cycle();
        frame_start = 0;
        chk("fs_empty", 32'(pix_valid), 0);
        #1 chk("underrun_pulse", 32'(underrun), 1);
        cycle();
        chk("fs_first_read", 32'(ram_addr), 0);
        pix_pop = 0;
        #1 chk("underrun_end", 32'(underrun), 0);

        // scan pointer wrap
        pix_pop = 1; wraps = 0; prev_addr = int'(ram_addr);
        repeat (130) begin
            cycle();
            if (prev_addr == SCAN - 1 && int'(ram_addr) != prev_addr) begin
                chk("scan_wrap", 32'(ram_addr), 0);
                wraps++;
            end
            prev_addr = int'(ram_addr);
        end
        chk("wrap_seen", 32'(wraps), 1);

        // randomized traffic, including mid-run reset and frame restarts
        repeat (1500) begin
            pix_pop     = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 199) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            if (!wr_valid || m_wr) begin
                wr_valid = $urandom_range(0, 1) == 1;
                wr_x = ($urandom_range(0, 15) == 0) ? 10'(640 + $urandom_range(0, 383)) : 10'($urandom_range(0, 639));
                wr_y = ($urandom_range(0, 15) == 0) ? 9'(480 + $urandom_range(0, 31)) : 9'($urandom_range(0, 479));
                wr_data = 4'($urandom);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fb_ram_arbiter.md
FB_RAM_ARBITER -- requirements
Module: fb_ram_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning scanout prefetch FIFO entries.
REQ-002 SHALL have parameter LOW_WATER, default 4, meaning the occupancy below which reads pre-empt writes.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port frame_start  input  1  single-cycle pulse marking the start of a frame.
REQ-006 SHALL have port pix_pop  input  1  scanout consumes the FIFO head this cycle.
REQ-007 SHALL have port pix_data  output  4  FIFO head pixel.
REQ-008 SHALL have port pix_valid  output  1  FIFO not empty.
REQ-009 SHALL have port underrun  output  1  one-cycle pulse when pix_pop is high while pix_valid is low.
REQ-010 SHALL have port wr_valid  input  1  draw-side write request.
REQ-011 SHALL have port wr_ready  output  1  write accepted this cycle (combinational grant).
REQ-012 SHALL have ports wr_x  input  10, wr_y  input  9, wr_data  input  4  write pixel column, row and value.
REQ-013 SHALL have port ram_addr  output  19  registered RAM address.
REQ-014 SHALL have ports ram_we  output  1 and ram_wdata  output  4  registered RAM write strobe and data.
REQ-015 SHALL have port ram_rdata  input  4  RAM read data, valid one clock after ram_addr is sampled.

Function
REQ-016 SHALL issue at most one RAM operation per cycle, read or write, never both.
REQ-017 SHALL define occupancy as FIFO count plus in-flight reads (0..2).
REQ-018 SHALL grant a read when occupancy < LOW_WATER, regardless of wr_valid.
REQ-019 SHALL otherwise grant the write if wr_valid=1; otherwise grant a read if occupancy < FIFO_DEPTH; otherwise idle.
REQ-020 SHALL never let occupancy exceed FIFO_DEPTH.
REQ-021 SHALL compute the write address as wr_y*640 + wr_x, 19-bit unsigned.
REQ-022 SHALL accept writes with wr_x >= 640 or wr_y >= 480 (wr_ready=1) but drop them with ram_we=0.
REQ-023 SHALL issue read addresses from a scan pointer that starts at 0 and increments by 1 per issued read.
REQ-024 SHALL wrap the scan pointer from 307199 to 0.
REQ-025 SHALL register granted ops onto ram_addr/ram_we/ram_wdata on the next edge.
REQ-026 SHALL push ram_rdata into the FIFO two edges after the grant edge.
REQ-027 SHALL hold ram_we=0 and ram_addr unchanged in idle cycles.
REQ-028 SHALL permit push and pop in the same cycle at any count, including full.
REQ-029 SHALL ignore pix_pop while the FIFO is empty, apart from pulsing underrun.
REQ-030 SHALL, on frame_start, empty the FIFO, squash in-flight reads (no push), and reset the scan pointer to 0.
REQ-031 SHALL grant a read at address 0 in the cycle after frame_start.
REQ-032 SHALL give frame_start precedence over a pix_pop or push in the same cycle.
REQ-033 SHALL let a write granted in the frame_start cycle complete normally.
REQ-034 SHALL, when wr_valid=1 and occupancy < LOW_WATER, hold wr_ready=0; wr_x, wr_y and wr_data then stay stable until wr_ready=1.

Reset
REQ-035 SHALL, while rst=1, drive pix_valid=0, pix_data=0, underrun=0, wr_ready=0, ram_we=0, ram_addr=0 and ram_wdata=0.
REQ-036 SHALL, while rst=1, empty the FIFO, clear in-flight state and set the scan pointer to 0.
REQ-037 SHALL, on reset asserted mid-operation, abandon in-flight reads; the first read after release is address 0.

Structure
REQ-038 SHALL take H_RES=640, V_RES=480, FB_DEPTH=307200, ADDR_W=19 and PIX_W=4 from shared package fb_pkg.
REQ-039 SHALL implement the FIFO as sub-module fb_prefetch_fifo (push, pop, flush, count, head), synchronous reset.

Verification
REQ-040 SHALL cover: reset release with wr_valid=0, no pops -> reads at addresses 0..7 on consecutive cycles, then idle; pix_valid=1 and pix_data=ram[0] at the FIFO head.
REQ-041 SHALL cover: full FIFO, wr_valid=1 (x=5, y=2, data=0xA) -> wr_ready=1, next cycle ram_we=1 with ram_addr=1285 and ram_wdata=0xA.
REQ-042 SHALL cover: a pop every cycle with wr_valid held at 1 -> occupancy never below 2, no underrun, writes granted only when occupancy >= 4.
REQ-043 SHALL cover: frame_start asserted while 2 reads are in flight -> FIFO empty next cycle, squashed data never appears, next read at address 0.
REQ-044 SHALL cover: scan pointer reaching 307199 with no frame_start -> following read at address 0.
REQ-045 SHALL cover: write with x=640, y=0 -> wr_ready=1, ram_we stays 0; pix_pop on empty FIFO -> underrun pulses for exactly 1 cycle.
